in_port: RTL
============

# in_port

Input-side counterpart of the output register: buffers 16-bit words offered by an external producer and hands them to the SIMPLE core when an IN instruction executes. Sits beside the output register, with its read strobe driven by the same phase/instruction decode that drives `ld_outr`. Its `rd_data` feeds the ALU result mux as the IN operand. A small FIFO decouples producer timing from the core's phase sequencing.

## Interface

Parameters:
- `WIDTH`, 16: data word width; matches the core register width.
- `DEPTH`, 4: FIFO entries; must be a power of two, minimum 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ext_valid`  in  1  producer offers `ext_data` this cycle.
- `ext_data`  in  WIDTH  producer word.
- `ext_ready`  out  1  block can accept a word this cycle.
- `rd_en`  in  1  one-cycle pulse from the IN-instruction decode; pops the head word.
- `rd_data`  out  WIDTH  last popped word (registered), read by the core.
- `empty`  out  1  no word buffered; the core's decode uses it to stall the IN instruction.
- `count`  out  clog2(DEPTH)+1  words currently buffered.
- `uflow`  out  1  sticky underflow flag (see Configuration).

## Operation

- Push: when `ext_valid && ext_ready`, `ext_data` is written at `wr_ptr`, `wr_ptr` increments modulo DEPTH, and `count` increments.
- `ext_ready` = !full, where full = (`count` == DEPTH). It is driven from registered state only, with no combinational path from `rd_en`, so a pop does not free a slot in the same cycle.
- Pop: when `rd_en && !empty`, `rd_data` loads `mem[rd_ptr]`, `rd_ptr` increments modulo DEPTH, and `count` decrements.
- Pop while empty: `rd_data`, the pointers and `count` are unchanged. The core is expected to stall on `empty`; a pop while empty is an underflow.
- Simultaneous push and pop, not full and not empty: both happen and `count` is unchanged. The pointers are independent, so there is no ordering hazard.
- Push into an empty FIFO with `rd_en` in the same cycle: the pop is treated as an underflow. There is no bypass, and the new word is stored.
- Pointer wrap: both pointers are log2(DEPTH) bits and wrap naturally. full/empty are decided by `count`, not by pointer compare.
- `ext_valid` while `ext_ready` = 0: no write. The producer must hold `ext_data` until it is accepted.
- `ext_data` is sampled only on an accepted push.

## Timing

- Reset values: `rd_data` = 0, `count` = 0, `empty` = 1, `ext_ready` = 1 after the first clock with `rst` low, `uflow` = 0, pointers = 0.
- While `rst` is high, `ext_ready` = 0 and pushes and pops are ignored.
- Reset mid-operation discards all buffered words. Memory contents are not cleared.
- Push latency: a word accepted at edge N is visible in `count`/`empty` after edge N. It can be popped by an `rd_en` sampled at edge N+1.
- Pop latency: `rd_data` updates at the same edge that samples `rd_en`. It holds until the next valid pop.
- Full to not-full: `ext_ready` rises in the cycle after the pop edge.
- Throughput: one push and one pop per cycle.

## Configuration

- `IN_PORT_UFLOW_EN` defined:
  - `uflow` is set on any `rd_en` while `empty`.
  - It stays set until `rst`.
- `IN_PORT_UFLOW_EN` undefined:
  - `uflow` is tied to 0 and no flag register is built.
  - Underflow behaviour is otherwise identical: the pop is ignored.

## Structure

- Shared package `simple_io_pkg` holds:
  - `WORD_W` = 16 and `IN_DEPTH_DEF` = 4;
  - the `word_t` typedef;
  - the helper for the `count` width.
  The output register is to use the same package.
- Sub-module `in_port_mem`: DEPTH×WIDTH storage with one synchronous write port and an asynchronous read at `rd_ptr`.
  - `rd_data` is registered in `in_port`, not in the memory.
  - This lets an inferred RAM replace it later.
- The top level holds the pointers, `count`, the `rd_data` register and the flag.

## Test plan

- Reset then idle:
  - stimulus: hold `rst` 2 cycles, release;
  - response: `empty` = 1, `count` = 0, `rd_data` = 0x0000, `ext_ready` = 1 one cycle after release, `uflow` = 0.
- Single transfer:
  - stimulus: push 0x1234; pulse `rd_en` next cycle;
  - response: `count` goes 1 then 0, `rd_data` = 0x1234 after the pop edge, `empty` returns to 1.
- Fill and wrap:
  - stimulus: push 0xA000..0xA003 (DEPTH = 4), then offer 0xA004 and hold it; pop once; continue alternating pushes and pops through 3 pointer wraps;
  - response: `ext_ready` = 0 while full and 0xA004 is not written; after the pop, `ext_ready` rises one cycle later and 0xA004 is accepted; data pops strictly in order.
- Simultaneous push and pop at `count` = 2:
  - stimulus: push and pop in the same cycle;
  - response: `count` stays 2 and `rd_data` = the oldest word.
- Underflow:
  - stimulus: pulse `rd_en` while empty;
  - response: `rd_data` is unchanged and `count` stays 0;
  - with the macro, `uflow` = 1 and sticks until `rst`; without it, `uflow` = 0.
- Reset mid-stream:
  - stimulus: with 3 words buffered, assert `rst` for one cycle;
  - response: `count` = 0, `empty` = 1, `rd_data` = 0; a subsequent push of 0x5555 pops as 0x5555.

Source files
------------

// File: rtl/simple_io_pkg.sv
// Shared definitions for the SIMPLE core I/O registers (input port, output register).
// Word width, default input FIFO depth and the count-width helper live here.
package simple_io_pkg;

    localparam int WORD_W       = 16;
    localparam int IN_DEPTH_DEF = 4;

    typedef logic [WORD_W-1:0] word_t;

    // Occupancy counter must reach DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/in_port_mem.sv
// Storage array for the input port FIFO: synchronous write, asynchronous read.
// Kept separate so an inferred RAM can replace it without touching the pointer logic.
module in_port_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_word
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem[rd_addr];

endmodule

// File: rtl/in_port.sv
// Input port for the SIMPLE core: small FIFO between an external producer and the IN instruction.
// Define IN_PORT_UFLOW_EN to build the sticky underflow flag; otherwise uflow is tied low.
module in_port
    import simple_io_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = IN_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ext_valid,
    input  logic [WIDTH-1:0]          ext_data,
    output logic                      ext_ready,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      uflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic             live;
    logic             full;
    logic             push;
    logic             pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // live keeps ext_ready low until one clean clock after reset release.
    assign ext_ready = live && !rst && !full;
    assign push      = ext_valid && ext_ready;
    assign pop       = rd_en && !empty;

    in_port_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (ext_data),
        .rd_addr (rd_ptr),
        .rd_word (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            live    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            live <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= head;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef IN_PORT_UFLOW_EN
    logic uflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            uflow_q <= 1'b0;
        end else if (rd_en && empty) begin
            uflow_q <= 1'b1;
        end
    end

    assign uflow = uflow_q;
`else
    assign uflow = 1'b0;
`endif

endmodule
